// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard interface: decoded source/destination info in, stall/flush controls out.
interface hazard_scoreboard_if #(
    parameter int NUM_REGS = 32,
    parameter int WIDTH_T  = 3
);
    localparam int AW = $clog2(NUM_REGS);

    logic               id_valid;
    logic [AW-1:0]      addr_rs;
    logic [AW-1:0]      addr_rt;
    logic [WIDTH_T-1:0] tuse_rs;
    logic [WIDTH_T-1:0] tuse_rt;
    logic [AW-1:0]      addr_dst;
    logic [WIDTH_T-1:0] tnew_id;
    logic               md_use;
    logic               md_start;
    logic               md_is_div;
    logic               flush_req;

    logic               stall_pc;
    logic               stall_id;
    logic               clr_ex;
    logic               clr_id;
    logic               clr_mem;
    logic               clr_wb;
    logic               dis_md;
    logic               dis_dm;
    logic               md_busy;
    logic [1:0]         stall_cause;
    logic [31:0]        stall_count;

    // Pipeline side: presents the ID instruction, obeys the controls.
    modport master (
        output id_valid, addr_rs, addr_rt, tuse_rs, tuse_rt, addr_dst, tnew_id,
               md_use, md_start, md_is_div, flush_req,
        input  stall_pc, stall_id, clr_ex, clr_id, clr_mem, clr_wb, dis_md, dis_dm,
               md_busy, stall_cause, stall_count
    );

    // Scoreboard side.
    modport slave (
        input  id_valid, addr_rs, addr_rt, tuse_rs, tuse_rt, addr_dst, tnew_id,
               md_use, md_start, md_is_div, flush_req,
        output stall_pc, stall_id, clr_ex, clr_id, clr_mem, clr_wb, dis_md, dis_dm,
               md_busy, stall_cause, stall_count
    );
endinterface

// File: rtl/hazard_scoreboard.sv
// Register scoreboard hazard unit: per-register Tnew countdowns plus an MD busy counter.
// Optional stall statistics counter enabled by defining HAZARD_STAT_EN.
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int WIDTH_T     = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic                clk,
    input  logic                reset,
    hazard_scoreboard_if.slave  sb
);
    localparam int AW     = $clog2(NUM_REGS);
    localparam int DEPTH  = 1 << AW;
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MDW    = $clog2(MD_MAX + 1);

    localparam logic [WIDTH_T-1:0] ONE_T     = WIDTH_T'(1);
    localparam logic [MDW-1:0]     ONE_MD    = MDW'(1);
    localparam logic [MDW-1:0]     MULT_LOAD = MDW'(MULT_CYCLES);
    localparam logic [MDW-1:0]     DIV_LOAD  = MDW'(DIV_CYCLES);

    // Entries outside 1..NUM_REGS-1 exist only so any address indexes safely; they stay 0.
    logic [DEPTH-1:0][WIDTH_T-1:0] cnt_reg;
    logic [DEPTH-1:0][WIDTH_T-1:0] cnt_next;
    logic [MDW-1:0]                md_cnt_reg;
    logic [MDW-1:0]                md_cnt_next;

    logic               haz_rs;
    logic               haz_rt;
    logic               haz_md;
    logic               hazard;
    logic               stall;
    logic               issue;
    logic               load_en;
    logic               md_busy;
    logic [WIDTH_T-1:0] tnew_m1;

    assign md_busy = (md_cnt_reg != '0);
    assign haz_rs  = sb.id_valid && (sb.addr_rs != '0) && (cnt_reg[sb.addr_rs] > sb.tuse_rs);
    assign haz_rt  = sb.id_valid && (sb.addr_rt != '0) && (cnt_reg[sb.addr_rt] > sb.tuse_rt);
    assign haz_md  = sb.id_valid && sb.md_use && md_busy;
    assign hazard  = haz_rs | haz_rt | haz_md;
    assign stall   = hazard && !sb.flush_req;
    assign issue   = sb.id_valid && !hazard && !sb.flush_req;
    assign load_en = issue && (sb.addr_dst != '0) && (sb.tnew_id != '0);
    assign tnew_m1 = sb.tnew_id - ONE_T;

    assign sb.stall_pc = stall;
    assign sb.stall_id = stall;
    assign sb.clr_ex   = hazard | sb.flush_req;
    assign sb.clr_id   = sb.flush_req;
    assign sb.clr_mem  = sb.flush_req;
    assign sb.clr_wb   = sb.flush_req;
    assign sb.dis_md   = sb.flush_req;
    assign sb.dis_dm   = sb.flush_req;
    assign sb.md_busy  = md_busy;

    always_comb begin
        sb.stall_cause = 2'd0;
        if (haz_rs) begin
            sb.stall_cause = 2'd1;
        end else if (haz_rt) begin
            sb.stall_cause = 2'd2;
        end else if (haz_md) begin
            sb.stall_cause = 2'd3;
        end
    end

    // Flush squashes every younger producer; a fresh load beats the decrement of its own entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cnt
            if (gi == 0 || gi >= NUM_REGS) begin : g_untracked
                assign cnt_next[gi] = '0;
            end else begin : g_tracked
                localparam logic [AW-1:0] IDX = AW'(gi);
                assign cnt_next[gi] = sb.flush_req                          ? '0 :
                                      (load_en && sb.addr_dst == IDX)       ? tnew_m1 :
                                      (cnt_reg[gi] != '0)                   ? cnt_reg[gi] - ONE_T :
                                                                              '0;
            end
        end
    endgenerate

    // The MD counter survives a flush: an operation already started belongs to an older instruction.
    always_comb begin
        md_cnt_next = md_cnt_reg;
        if (issue && sb.md_start) begin
            md_cnt_next = sb.md_is_div ? DIV_LOAD : MULT_LOAD;
        end else if (md_busy) begin
            md_cnt_next = md_cnt_reg - ONE_MD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg    <= '0;
            md_cnt_reg <= '0;
        end else begin
            cnt_reg    <= cnt_next;
            md_cnt_reg <= md_cnt_next;
        end
    end

`ifdef HAZARD_STAT_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_count_reg <= '0;
        end else if (stall) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign sb.stall_count = stall_count_reg;
`else
    assign sb.stall_count = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised successor to the pipeline stall/flush controller. It replaces per-stage Tnew/address comparisons with a register scoreboard: one saturating Tnew countdown per architectural register, plus an internal multiply/divide busy counter. It sits beside the ID stage and drives the PC and ID/EX stall and clear signals, and the exception flush fan-out, for the five-stage pipeline.

## Interface
- `NUM_REGS`, default 32: number of architectural GPRs tracked. Register 0 is never tracked.
- `WIDTH_T`, default 3: width of every Tuse, Tnew and countdown value. The all-ones value means "never used" (TUSE_INF).
- `MULT_CYCLES`, default 5: busy cycles for MULT/MULTU.
- `DIV_CYCLES`, default 10: busy cycles for DIV/DIVU.

Ports (`AW` = clog2(`NUM_REGS`)):
- `clk` input 1: clock. Rising edge only.
- `reset` input 1: synchronous, active-high.
- `id_valid` input 1: the ID stage holds a real instruction.
- `addr_rs`, `addr_rt` input AW: source registers read in ID.
- `tuse_rs`, `tuse_rt` input WIDTH_T: Tuse of each source.
- `addr_dst` input AW: destination register of the ID instruction.
- `tnew_id` input WIDTH_T: Tnew of the ID instruction, counted at ID.
- `md_use` input 1: the ID instruction is any MD-class instruction.
- `md_start` input 1: the ID instruction is MULT/MULTU/DIV/DIVU.
- `md_is_div` input 1: qualifies `md_start`.
- `flush_req` input 1: CP0 requests exception entry or ERET.
- `stall_pc`, `stall_id`, `clr_ex` output 1: hazard stall set.
- `clr_id`, `clr_mem`, `clr_wb` output 1: flush set.
- `dis_md`, `dis_dm` output 1: suppress MD start and DM write.
- `md_busy` output 1: the MD unit is occupied.
- `stall_cause` output 2: 0 none, 1 rs, 2 rt, 3 md. Priority is rs > rt > md.
- `stall_count` output 32: count of cycles with a hazard stall.

## Operation
- State:
  - `cnt[r]`, WIDTH_T bits, for r = 1..NUM_REGS-1.
  - `md_cnt`, wide enough for max(MULT_CYCLES, DIV_CYCLES).
  - `stall_count`.
- Source hazards:
  - `haz_rs` = id_valid && addr_rs != 0 && cnt[addr_rs] > tuse_rs.
  - `haz_rt` is the same test using rt.
- MD hazard: `haz_md` = id_valid && md_use && md_busy.
- `hazard` = haz_rs | haz_rt | haz_md.
- Stall outputs: `stall_pc` = `stall_id` = hazard && !flush_req.
- `clr_ex` = hazard | flush_req.
- Flush outputs: `clr_id` = `clr_mem` = `clr_wb` = `dis_md` = `dis_dm` = flush_req.
- Issue: `issue` = id_valid && !hazard && !flush_req.
- Scoreboard update, each cycle:
  - Every nonzero `cnt[r]` decrements by 1.
  - On `issue` with addr_dst != 0 and tnew_id != 0, load `cnt[addr_dst]` with tnew_id-1. The load overrides that register's decrement.
  - A younger write to the same register overwrites the older value; this is program order.
- MD counter:
  - On `issue && md_start`, load `md_cnt` with DIV_CYCLES if md_is_div, otherwise MULT_CYCLES.
  - Otherwise a nonzero `md_cnt` decrements by 1.
  - `md_busy` = (md_cnt != 0).
- Flush:
  - `flush_req` clears every `cnt[r]` to 0 at the edge, because all younger instructions are squashed.
  - `md_cnt` is not cleared: an MD operation already started belongs to a committed older instruction.
  - A `md_start` in a flush cycle is ignored.
- Arithmetic:
  - All Tnew/Tuse comparisons are unsigned.
  - Counters never wrap below 0.
  - tnew_id = 0 loads nothing.

## Timing
- Reset: all `cnt[r]` = 0, `md_cnt` = 0, `stall_count` = 0. All outputs are 0 while `flush_req` and `id_valid` are 0.
- All stall and flush outputs are combinational from the inputs and current state, valid in the same cycle. There is no extra latency.
- Scoreboard, MD counter and statistics update only at the rising edge of `clk`.
- A producer issued at edge n is visible to the consumer in ID at cycle n+1 with count tnew_id-1. This equals its Tnew in EX.
- `md_busy` rises the cycle after `md_start` issues and stays high for exactly MULT_CYCLES or DIV_CYCLES cycles.
- `reset` mid-operation abandons all pending counts and the MD occupancy within one edge.

## Configuration
- `HAZARD_STAT_EN`:
  - Defined: `stall_count` increments (wrapping at 2^32) every cycle in which `stall_pc` is 1. Reset clears it.
  - Undefined: the counter logic is not compiled and `stall_count` is tied to 0.
  - All other behaviour is identical in both cases.

## Test plan
- Load-use: LW $1 issues (tnew_id=3), then ADD with rs=$1 (tuse_rs=1). Required: exactly one stall cycle with stall_cause=1, then issue; stall_count=1 when enabled.
- LW $2 followed by BEQ with rt=$2 (tuse_rt=0). Required: two stall cycles with stall_cause=2, clr_ex=1 both cycles.
- Back-to-back writers: ADDU $3 (tnew 2), then LB $3 (tnew 5), then a consumer with tuse 1. Required: the stall follows the LB count (4→…), not the ADDU count.
- MD: DIV issues (DIV_CYCLES=10), MFLO follows. Required: md_busy high for 10 cycles, stall_cause=3 throughout, MFLO issues on cycle 11.
- Flush: flush_req while cnt[5]=2 and MULT is busy. Required: clr_id/clr_ex/clr_mem/clr_wb/dis_md/dis_dm=1 and stall_pc=0 that cycle; next cycle cnt[5]=0 with no stall on $5, md_busy still high.
- Register 0: a producer to $0 and a consumer of $0 with a large tnew produce no stall.
